// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO registers.
// One result bit per cycle: radix-2 shift-add multiply, restoring shift-subtract divide.
module mul_div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a_port,
  input  logic [31:0] b_port,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Operand preparation at accept time: ops 0xx are arithmetic, xx0 of those are signed.
  logic        is_arith;
  logic        is_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign is_arith  = (op[2] == 1'b0);
  assign is_signed = is_arith && (op[0] == 1'b0);
  assign mag_a     = (is_signed && a_port[31]) ? (~a_port + 32'd1) : a_port;
  assign mag_b     = (is_signed && b_port[31]) ? (~b_port + 32'd1) : b_port;

  // Multiply keeps the multiplier in acc[31:0] and shifts the product in from the top.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

  // Divide keeps the remainder in acc[63:32] and shifts quotient bits into acc[31:0].
  logic [32:0] div_part;
  logic [32:0] div_diff;
  logic        div_fits;
  assign div_part = {acc_q[63:32], acc_q[31]};
  assign div_diff = div_part - {1'b0, opnd_q};
  assign div_fits = (div_part >= {1'b0, opnd_q});

  logic [63:0] step_acc;
  always_comb begin
    step_acc = {mul_sum, acc_q[31:1]};
    if (is_div_q) begin
      step_acc = {(div_fits ? div_diff[31:0] : div_part[31:0]), acc_q[30:0], div_fits};
    end
  end

  // Sign fix-up of the magnitude result; divide-by-zero overrides everything.
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
  assign quot_fix = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi = a_raw_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_fix;
        res_lo = quot_fix;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (is_arith) begin
            state_d    = CALC;
            busy_d     = 1'b1;
            count_d    = 5'd31;
            is_div_d   = op[1];
            a_raw_d    = a_port;
            neg_res_d  = is_signed && (a_port[31] ^ b_port[31]);
            neg_rem_d  = is_signed && op[1] && a_port[31];
            div_zero_d = op[1] && (b_port == 32'd0);
            if (op[1]) begin
              acc_d  = {32'd0, mag_a};
              opnd_d = mag_b;
            end else begin
              acc_d  = {32'd0, mag_b};
              opnd_d = mag_a;
            end
          end else if (op == OP_MTHI) begin
            hi_d = a_port;
          end else if (op == OP_MTLO) begin
            lo_d = a_port;
          end
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          count_d = 5'd0;
        end else begin
          acc_d = step_acc;
          if (count_q == 5'd0) begin
            state_d = FINISH;
          end else begin
            count_d = count_q - 5'd1;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      count_q    <= 5'd0;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      a_raw_q    <= 32'd0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic results, busy/done timing,
// MTHI/MTLO, ignored starts, flush and asynchronous reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  op_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op_in),
    .a_port (a_in),
    .b_port (b_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge (cycle T); accepted at the next edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int mtlo_at);
    int bad;
    start = 1'b1; op_in = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (c == mtlo_at) begin
        start = 1'b1; op_in = 3'b101; a_in = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check({tag, "_busy33"}, 64'(bad), 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, o, a, b, hi, lo);
  endtask

  // Starts an op, flushes it at cycle T+10, and checks nothing is committed.
  task automatic flush_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] old_hi,
                          input logic [31:0] old_lo);
    int bad;
    start = 1'b1; op_in = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    for (int c = 1; c < 10; c++) begin
      if (busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check({tag, "_busy_pre"}, 64'(bad), 64'd0);
    check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0 || hi !== old_hi || lo !== old_lo) bad++;
      @(posedge clk); #1;
    end
    check({tag, "_quiet"}, 64'(bad), 64'd0);
    $display("[TB] %s flushed op=%0d a=%h b=%h -> hi=%h lo=%h", tag, o, a, b, hi, lo);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; op_in = 3'b000; a_in = 32'd0; b_in = 32'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    $display("[TB] reset released hi=%h lo=%h", hi, lo);
    @(posedge clk); #1;

    // Back-to-back: each op starts in the done cycle of the previous one.
    run_op("mult_neg3x5",  3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("multu_max",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_minmin",  3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run_op("div_m7_2",     3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_7_m2",     3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("divu_100_0",   3'b011, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 0);
    run_op("div_m100_0",   3'b010, 32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF, 0);
    run_op("div_min_m1",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);

    // MTHI issued in the done cycle.
    start = 1'b1; op_in = 3'b100; a_in = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    check("mthi_lo", {32'd0, lo}, 64'h8000_0000);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    check("mthi_done", {63'd0, done}, 64'd0);
    $display("[TB] mthi a=12345678 -> hi=%h lo=%h", hi, lo);

    // Reserved op with start is ignored.
    start = 1'b1; op_in = 3'b110; a_in = 32'hAAAA_AAAA; b_in = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("nop_busy", {63'd0, busy}, 64'd0);
    check("nop_hilo", {hi, lo}, 64'h1234_5678_8000_0000);
    $display("[TB] op110 ignored -> hi=%h lo=%h", hi, lo);

    // MTLO together with flush in IDLE is suppressed.
    start = 1'b1; flush = 1'b1; op_in = 3'b101; a_in = 32'h5555_5555;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("mtlo_flush_lo", {32'd0, lo}, 64'h8000_0000);
    $display("[TB] mtlo+flush suppressed -> lo=%h", lo);

    // MTLO while busy is dropped; the in-flight result lands.
    run_op("divu_9_2_mtlo", 3'b011, 32'd9, 32'd2, 32'h0000_0001, 32'h0000_0004, 5);

    flush_op("divu_flush", 3'b011, 32'd100, 32'd7, 32'h0000_0001, 32'h0000_0004);

    // Asynchronous reset in the middle of an operation.
    start = 1'b1; op_in = 3'b001; a_in = 32'hFFFF_FFFF; b_in = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    #1;
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    $display("[TB] async reset mid-op -> hi=%h lo=%h busy=%0d", hi, lo, busy);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("arst_idle_busy", {63'd0, busy}, 64'd0);

    run_op("multu_3x4", 3'b001, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the EX stage, directly downstream of the ALU operand selector. It consumes the same selected operands (`a_port`, `b_port`) and executes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers, and performs MTHI/MTLO writes. The pipeline control stalls on `busy` and reads HI/LO for MFHI/MFLO.

## Interface
- No parameters; all widths fixed at 32-bit operands, 64-bit HI:LO.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted only when `busy`=0.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- `a_port` in 32: multiplicand / dividend / MTHI-MTLO data.
- `b_port` in 32: multiplier / divisor.
- `flush` in 1: abort the in-flight operation (exception/branch squash).
- `busy` out 1: operation in progress; pipeline must stall dependent MFHI/MFLO.
- `done` out 1: one-cycle pulse, HI/LO hold the new result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, CALC (32 iterations), FINISH (sign fix-up and HI/LO write).
- IDLE: on `start`=1 and op in {MULT, MULTU, DIV, DIVU}, latch op, operand magnitudes, and result sign flags; load 5-bit iteration counter with 31; go to CALC.
- MTHI/MTLO: at the accepting edge, write `a_port` to `hi`/`lo` directly. Stay IDLE; no `busy`, no `done`.
- op 110/111 with `start`: ignored.
- Signed ops use magnitudes: |x| of 0x80000000 is 0x80000000 as unsigned. Unsigned ops use raw operands.
- Multiply: radix-2 shift-add over a 64-bit accumulator, one bit per CALC cycle.
- Divide: restoring shift-subtract, one quotient bit per CALC cycle, 33-bit partial remainder.
- CALC: the counter decrements each cycle; at counter 0, go to FINISH.
- FINISH, signed fix-up:
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the sign of the dividend.
- FINISH writes: `lo` = product[31:0] or quotient; `hi` = product[63:32] or remainder. Return to IDLE.
- Divide by zero (signed or unsigned): `lo`=0xFFFFFFFF, `hi`=raw `a_port` as latched. Timing is unchanged (full 34 cycles).
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. No trap.
- `start` while `busy`=1: ignored, not queued. This includes MTHI/MTLO.
- `flush`=1 in CALC or FINISH: go to IDLE next edge. HI/LO are not written and `done` is not pulsed.
- `flush` in IDLE together with `start`: the start is suppressed, including MTHI/MTLO.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0, internal accumulators 0.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded.
- Accept at edge E (cycle T):
  - `busy`=1 for cycles T+1 .. T+33 (32 CALC + 1 FINISH).
  - Cycle T+34: `busy`=0, `done`=1, and `hi`/`lo` show the result.
- A new `start` in the `done` cycle is accepted (back-to-back, no bubble).
- `busy` is registered and is never high in the same cycle as `done`.
- MTHI/MTLO: the new value is visible on `hi`/`lo` in the cycle after the accepting edge.
- `hi`/`lo` change only at a FINISH edge or an MTHI/MTLO accept.

## Test plan
- MULT `a`=0xFFFFFFFD (−3), `b`=5 → after 34 cycles `done`=1, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; `busy` high exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV 7 / −2 → `lo`=0xFFFFFFFD, `hi`=0x00000001.
- DIVU 100 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00000064.
- DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI 0x12345678 while IDLE → `hi`=0x12345678 next cycle, `lo` unchanged, no `done`.
- MTLO issued while `busy` → ignored; the final `lo` equals the in-flight result.
- Start DIVU 9/2, assert `flush` at cycle T+10 → `busy`=0 at T+11, HI/LO keep their old values, no `done` ever.
- Start MULTU, pull `resetn` low at T+5 → all outputs 0 immediately.
- After reset release, MULTU 3×4 runs normally → `lo`=12, `hi`=0.
